// File: rtl/sram_pkg.sv
// Shared definitions for the external 8-bit asynchronous SRAM arbiter.
// Holds the sequencer state encoding, the port identifiers and the SRAM
// data width.
package sram_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STROBE = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   localparam int DW = 8;

endpackage

// File: rtl/sram_rr_grant.sv
// Two-input round-robin grant for the SRAM arbiter.
// Ports:
//   clk, rst    : system clock, async active-high reset
//   i_req_a/b   : port requests
//   i_en        : record i_port as the most recently served port
//   i_port      : port that has just been served
//   o_grant     : port that would be granted now (PORT_A / PORT_B)
// The "last served" register resets to PORT_B so that A wins the first tie.
import sram_pkg::*;

module sram_rr_grant (
   input  logic clk,
   input  logic rst,
   input  logic i_req_a,
   input  logic i_req_b,
   input  logic i_en,
   input  logic i_port,
   output logic o_grant
);

   logic r_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last <= PORT_B;
      end else if (i_en) begin
         r_last <= i_port;
      end
   end

   // On a tie the port not served last wins; otherwise the lone requester.
   always_comb begin
      if (i_req_a && i_req_b) begin
         o_grant = ~r_last;
      end else if (i_req_a) begin
         o_grant = PORT_A;
      end else begin
         o_grant = PORT_B;
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter and cycle sequencer for an external 8-bit async SRAM.
// Port A (core) and port B (DMA/video) issue single-byte accesses; the
// sequencer runs IDLE -> SETUP -> STROBE(ACCESS_CYCLES) -> HOLD and drives
// the SRAM pins from registers only.
//
// state  | meaning
// IDLE   | no access in flight, waiting for a request
// SETUP  | address (and write data) registered, strobe still inactive
// STROBE | write strobe low / read data settling, down-counter running
// HOLD   | strobe released, address/data held, ack pulse to the port
//
// Ports:
//   clk, rst                 : system clock, async active-high reset
//   a_* / b_*                : req/we/addr/wdata in, ack/rdata out per port
//   sram_addr, sram_dout     : registered address and write data
//   sram_doe                 : data-bus output enable
//   sram_din                 : data read from the SRAM pins
//   sram_we_n                : active-low write strobe
//   busy                     : high whenever the sequencer is not IDLE
module sram_arbiter
   import sram_pkg::*;
#(
   parameter int AW            = 21,
   parameter int ACCESS_CYCLES = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic          a_ack,
   output logic [DW-1:0] a_rdata,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic          b_ack,
   output logic [DW-1:0] b_rdata,
   output logic [AW-1:0] sram_addr,
   output logic [DW-1:0] sram_dout,
   output logic          sram_doe,
   input  logic [DW-1:0] sram_din,
   output logic          sram_we_n,
   output logic          busy
);

   localparam logic [3:0] LP_CNT_LOAD = 4'(ACCESS_CYCLES - 1);

   state_t        r_state, w_nxt_state;
   logic [3:0]    r_cnt, w_nxt_cnt;
   logic          r_port, w_nxt_port;
   logic          r_we, w_nxt_we;
   logic [AW-1:0] r_addr, w_nxt_addr;
   logic [DW-1:0] r_dout, w_nxt_dout;
   logic          r_doe, w_nxt_doe;
   logic          r_we_n, w_nxt_we_n;
   logic          r_a_ack, w_nxt_a_ack;
   logic          r_b_ack, w_nxt_b_ack;
   logic [DW-1:0] r_a_rdata, w_nxt_a_rdata;
   logic [DW-1:0] r_b_rdata, w_nxt_b_rdata;
   logic          r_busy, w_nxt_busy;

   logic          w_grant;
   logic          w_hold;
   logic          w_sel_port;
   logic          w_sel_we;
   logic [AW-1:0] w_sel_addr;
   logic [DW-1:0] w_sel_wdata;
   logic          w_other_req;

   assign w_hold = (r_state == ST_HOLD);

   sram_rr_grant u_grant (
      .clk     (clk),
      .rst     (rst),
      .i_req_a (a_req),
      .i_req_b (b_req),
      .i_en    (w_hold),
      .i_port  (r_port),
      .o_grant (w_grant)
   );

   // From HOLD the only candidate is the other port; the port just acked
   // has to come back through IDLE.
   assign w_sel_port  = w_hold ? ~r_port : w_grant;
   assign w_sel_we    = (w_sel_port == PORT_B) ? b_we    : a_we;
   assign w_sel_addr  = (w_sel_port == PORT_B) ? b_addr  : a_addr;
   assign w_sel_wdata = (w_sel_port == PORT_B) ? b_wdata : a_wdata;
   assign w_other_req = (r_port == PORT_B) ? a_req : b_req;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_port    <= PORT_A;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_dout    <= '0;
         r_doe     <= 1'b0;
         r_we_n    <= 1'b1;
         r_a_ack   <= 1'b0;
         r_b_ack   <= 1'b0;
         r_a_rdata <= '0;
         r_b_rdata <= '0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_nxt_state;
         r_cnt     <= w_nxt_cnt;
         r_port    <= w_nxt_port;
         r_we      <= w_nxt_we;
         r_addr    <= w_nxt_addr;
         r_dout    <= w_nxt_dout;
         r_doe     <= w_nxt_doe;
         r_we_n    <= w_nxt_we_n;
         r_a_ack   <= w_nxt_a_ack;
         r_b_ack   <= w_nxt_b_ack;
         r_a_rdata <= w_nxt_a_rdata;
         r_b_rdata <= w_nxt_b_rdata;
         r_busy    <= w_nxt_busy;
      end
   end

   // Every output is computed one cycle ahead from the next state, so the
   // pins change exactly on the edge that enters the corresponding state.
   always_comb begin
      w_nxt_state   = r_state;
      w_nxt_cnt     = r_cnt;
      w_nxt_port    = r_port;
      w_nxt_we      = r_we;
      w_nxt_addr    = r_addr;
      w_nxt_dout    = r_dout;
      w_nxt_doe     = r_doe;
      w_nxt_we_n    = 1'b1;
      w_nxt_a_ack   = 1'b0;
      w_nxt_b_ack   = 1'b0;
      w_nxt_a_rdata = r_a_rdata;
      w_nxt_b_rdata = r_b_rdata;

      case (r_state)
         ST_IDLE: begin
            if (a_req || b_req) begin
               w_nxt_state = ST_SETUP;
               w_nxt_port  = w_sel_port;
               w_nxt_we    = w_sel_we;
               w_nxt_addr  = w_sel_addr;
               w_nxt_doe   = w_sel_we;
               if (w_sel_we) w_nxt_dout = w_sel_wdata;
            end
         end
         ST_SETUP: begin
            w_nxt_state = ST_STROBE;
            w_nxt_cnt   = LP_CNT_LOAD;
            w_nxt_we_n  = ~r_we;
         end
         ST_STROBE: begin
            if (r_cnt == 4'd0) begin
               w_nxt_state = ST_HOLD;
               if (r_port == PORT_A) begin
                  w_nxt_a_ack = 1'b1;
                  if (!r_we) w_nxt_a_rdata = sram_din;
               end else begin
                  w_nxt_b_ack = 1'b1;
                  if (!r_we) w_nxt_b_rdata = sram_din;
               end
            end else begin
               w_nxt_cnt  = r_cnt - 4'd1;
               w_nxt_we_n = ~r_we;
            end
         end
         ST_HOLD: begin
            if (w_other_req) begin
               w_nxt_state = ST_SETUP;
               w_nxt_port  = w_sel_port;
               w_nxt_we    = w_sel_we;
               w_nxt_addr  = w_sel_addr;
               w_nxt_doe   = w_sel_we;
               if (w_sel_we) w_nxt_dout = w_sel_wdata;
            end else begin
               w_nxt_state = ST_IDLE;
               w_nxt_doe   = 1'b0;
            end
         end
         default: begin
            w_nxt_state = ST_IDLE;
            w_nxt_doe   = 1'b0;
         end
      endcase

      w_nxt_busy = (w_nxt_state != ST_IDLE);
   end

   assign sram_addr = r_addr;
   assign sram_dout = r_dout;
   assign sram_doe  = r_doe;
   assign sram_we_n = r_we_n;
   assign a_ack     = r_a_ack;
   assign b_ack     = r_b_ack;
   assign a_rdata   = r_a_rdata;
   assign b_rdata   = r_b_rdata;
   assign busy      = r_busy;

endmodule
